instr_reg_sched: RTL and testbench

INSTR_REG_SCHED -- requirements
Module: instr_reg_sched

---
 rtl/instr_reg_sched.sv | 158 +++++++++++++++
 tb/tb_instr_reg_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_reg_sched.sv
// instr_reg_sched
//   Round-robin write scheduler for a DEPTH-entry instruction register.
//   Two requesters (A, B) compete for one write slot per cycle. The block
//   owns the write and read pointers and the occupancy count. The register
//   storage itself lives outside this block and is written via load_en.
//
// Ports
//   clk, reset                   rising-edge clock, synchronous active-high reset
//   a_req/a_opcode/a_operand_*   requester A write request and instruction
//   b_req/b_opcode/b_operand_*   requester B write request and instruction
//   a_gnt, b_gnt                 one-hot-or-zero grants, combinational
//   flush                        drain stored entries, then return to IDLE
//   rd_ready, rd_valid           consumer handshake on the entry at read_pointer
//   load_en, opcode, operand_*   write strobe and muxed fields of the winner
//   write_pointer, read_pointer  register write/read addresses
//   count                        stored unread entries, 0..DEPTH
//   busy                         FSM is not in IDLE
//   state_dbg                    raw FSM state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Handshakes: a requester's instruction is taken on any cycle where its
// gnt is high (req&gnt); an entry is consumed on any cycle where
// rd_valid&rd_ready. Neither side may assume the other holds its signal.

package instr_reg_sched_pkg;
  typedef logic [4:0] address_t;
  typedef logic [3:0] opcode_t;
  typedef logic [7:0] operand_t;
  localparam opcode_t OP_ADD = 4'h1;
endpackage

module instr_reg_sched
  import instr_reg_sched_pkg::*;
#(
  // Must equal 2**$bits(address_t) so pointers wrap naturally.
  parameter int DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_req,
  input  opcode_t                    a_opcode,
  input  operand_t                   a_operand_a,
  input  operand_t                   a_operand_b,
  output logic                       a_gnt,
  input  logic                       b_req,
  input  opcode_t                    b_opcode,
  input  operand_t                   b_operand_a,
  input  operand_t                   b_operand_b,
  output logic                       b_gnt,
  input  logic                       flush,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic                       load_en,
  output opcode_t                    opcode,
  output operand_t                   operand_a,
  output operand_t                   operand_b,
  output address_t                   write_pointer,
  output address_t                   read_pointer,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic [1:0]                 state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  address_t        wr_ptr;
  address_t        rd_ptr;
  logic [CW-1:0]   count_r;
  logic            prio_b;     // 1: B wins the next tie
  logic            full;
  logic            grant_ok;
  logic            grant;
  logic            pop;
  logic [CW-1:0]   count_next;

  // Grants depend on registered state plus the current requests. A flush
  // arriving in RUN also blocks the grant that same cycle, so nothing new
  // slips in behind a drain request.
  always_comb begin
    full     = (count_r == CW'(DEPTH));
    grant_ok = !reset && !full && (state != DRAIN) && !((state == RUN) && flush);
    a_gnt    = grant_ok && a_req && (!b_req || !prio_b);
    b_gnt    = grant_ok && b_req && (!a_req ||  prio_b);
    grant    = a_gnt || b_gnt;
    pop      = (count_r != '0) && rd_ready;
  end

  always_comb begin
    count_next = count_r;
    case ({grant, pop})
      2'b10:   count_next = count_r + CW'(1);
      2'b01:   count_next = count_r - CW'(1);
      default: count_next = count_r;
    endcase
  end

  always_comb begin
    load_en   = grant;
    opcode    = '0;
    operand_a = '0;
    operand_b = '0;
    if (a_gnt) begin
      opcode    = a_opcode;
      operand_a = a_operand_a;
      operand_b = a_operand_b;
    end else if (b_gnt) begin
      opcode    = b_opcode;
      operand_a = b_operand_a;
      operand_b = b_operand_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
      prio_b  <= 1'b0;
    end else begin
      count_r <= count_next;
      if (grant) begin
        wr_ptr <= wr_ptr + address_t'(1);
        prio_b <= a_gnt;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + address_t'(1);
      end
      case (state)
        IDLE: begin
          if (grant) state <= RUN;
        end
        RUN: begin
          if (flush)                 state <= DRAIN;
          else if (count_next == '0) state <= IDLE;
        end
        DRAIN: begin
          if (count_next == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rd_valid      = (count_r != '0);
  assign write_pointer = wr_ptr;
  assign read_pointer  = rd_ptr;
  assign count         = count_r;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_instr_reg_sched.sv
module tb_instr_reg_sched;
  import instr_reg_sched_pkg::*;

  localparam int DEPTH = 32;
  localparam int EW    = 41;

  // ---------------- clock / reset block ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       a_req = 1'b0, b_req = 1'b0, flush = 1'b0, rd_ready = 1'b0;
  opcode_t    a_opcode = '0, b_opcode = '0;
  operand_t   a_operand_a = '0, a_operand_b = '0, b_operand_a = '0, b_operand_b = '0;
  logic       a_gnt, b_gnt, rd_valid, load_en, busy;
  opcode_t    opcode;
  operand_t   operand_a, operand_b;
  address_t   write_pointer, read_pointer;
  logic [5:0] count;
  logic [1:0] state_dbg;

  instr_reg_sched #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_opcode(a_opcode), .a_operand_a(a_operand_a),
    .a_operand_b(a_operand_b), .a_gnt(a_gnt),
    .b_req(b_req), .b_opcode(b_opcode), .b_operand_a(b_operand_a),
    .b_operand_b(b_operand_b), .b_gnt(b_gnt),
    .flush(flush), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .load_en(load_en), .opcode(opcode), .operand_a(operand_a),
    .operand_b(operand_b), .write_pointer(write_pointer),
    .read_pointer(read_pointer), .count(count), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic logic [EW-1:0] pack(
    input logic ag, input logic bg, input logic le, input logic [3:0] op,
    input logic [7:0] oa, input logic [7:0] ob, input logic [4:0] wp,
    input logic rv, input logic [4:0] rp, input logic [5:0] cnt, input logic bz);
    return {ag, bg, le, op, oa, ob, wp, rv, rp, cnt, bz};
  endfunction

  // Monitor: every cycle with an expectation queued, compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e, a;
      e = exp_q.pop_front();
      a = pack(a_gnt, b_gnt, load_en, opcode, operand_a, operand_b,
               write_pointer, rd_valid, read_pointer, count, busy);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs cycle=%0d got={gA%b gB%b ld%b op%h a%h b%h wp%0d rv%b rp%0d cnt%0d bz%b} want={gA%b gB%b ld%b op%h a%h b%h wp%0d rv%b rp%0d cnt%0d bz%b}",
          cyc, a[40], a[39], a[38], a[37:34], a[33:26], a[25:18], a[17:13], a[12], a[11:7], a[6:1], a[0],
          e[40], e[39], e[38], e[37:34], e[33:26], e[25:18], e[17:13], e[12], e[11:7], e[6:1], e[0]);
      end
    end
  end

  // ---------------- reference model ----------------
  // Occupancy is a queue of the addresses written, in write order; the
  // scheduler's read pointer must always name the oldest one.
  logic [4:0] addr_q[$];
  int  m_wr = 0, m_rd = 0;
  bit  m_last_a = 0;      // last winner was A; cleared at reset so A leads
  bit  m_busy = 0, m_drain = 0, m_known = 0;

  // ---------------- driver ----------------
  task automatic cycle(input bit ar, input bit br, input bit fl, input bit rr, input bit rst);
    bit ok, ga, gb, pop;
    logic [3:0] op;
    logic [7:0] oa, ob;
    logic [4:0] rp;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst; a_req = ar; b_req = br; flush = fl; rd_ready = rr;
    a_opcode    = opcode_t'($urandom_range(0, 15));
    a_operand_a = operand_t'($urandom_range(0, 255));
    a_operand_b = operand_t'($urandom_range(0, 255));
    b_opcode    = opcode_t'($urandom_range(0, 15));
    b_operand_a = operand_t'($urandom_range(0, 255));
    b_operand_b = operand_t'($urandom_range(0, 255));

    ok = !rst && (addr_q.size() < DEPTH) && !m_drain && !(m_busy && fl);
    ga = 0; gb = 0;
    if (ok) begin
      if (ar && br) begin
        if (m_last_a) gb = 1; else ga = 1;
      end else if (ar) ga = 1;
      else if (br) gb = 1;
    end
    op = 0; oa = 0; ob = 0;
    if (ga) begin op = a_opcode; oa = a_operand_a; ob = a_operand_b; end
    if (gb) begin op = b_opcode; oa = b_operand_a; ob = b_operand_b; end
    rp = (addr_q.size() > 0) ? addr_q[0] : m_rd[4:0];
    if (m_known)
      exp_q.push_back(pack(ga, gb, ga | gb, op, oa, ob, m_wr[4:0],
                           addr_q.size() > 0, rp, 6'(addr_q.size()), m_busy));

    if (rst) begin
      addr_q.delete();
      m_wr = 0; m_rd = 0; m_last_a = 0; m_busy = 0; m_drain = 0; m_known = 1;
    end else if (m_known) begin
      pop = (addr_q.size() > 0) && rr;
      if (pop) begin
        void'(addr_q.pop_front());
        m_rd = (m_rd + 1) % DEPTH;
      end
      if (ga || gb) begin
        addr_q.push_back(m_wr[4:0]);
        m_wr = (m_wr + 1) % DEPTH;
        m_last_a = ga;
      end
      if (!m_busy) begin
        if (ga || gb) m_busy = 1;
      end else if (!m_drain) begin
        if (fl) m_drain = 1;
        else if (addr_q.size() == 0) m_busy = 0;
      end else if (addr_q.size() == 0) begin
        m_busy = 0; m_drain = 0;
      end
    end
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    do_reset();
    cycle(0, 0, 0, 0, 0);               // reset state

    // Single write with ADD,5,3, then observe it next cycle.
    @(posedge clk); #1;
    reset = 0; a_req = 1; b_req = 0; flush = 0; rd_ready = 0;
    a_opcode = OP_ADD; a_operand_a = 8'd5; a_operand_b = 8'd3;
    exp_q.push_back(pack(1, 0, 1, OP_ADD, 8'd5, 8'd3, 5'd0, 0, 5'd0, 6'd0, 0));
    addr_q.push_back(5'd0); m_wr = 1; m_last_a = 1; m_busy = 1;
    cyc++;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);                // flush in IDLE: ignored

    // Contention: A,B,A,B.
    do_reset();
    repeat (4) cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Full, then one pop frees a slot usable only in the following cycle.
    do_reset();
    repeat (36) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);

    // Wrap: interleaved writes and pops.
    do_reset();
    repeat (120) cycle($urandom_range(0, 1), $urandom_range(0, 1), 0,
                       $urandom_range(0, 9) < 6, 0);

    // Flush with requests held high.
    do_reset();
    repeat (3) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);                // extra flush in DRAIN
    repeat (3) cycle(1, 0, 0, 1, 0);
    repeat (2) cycle(1, 0, 0, 0, 0);

    // Reset mid-run.
    do_reset();
    repeat (10) cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 0);
    cycle(1, 1, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0);

    // Random soak with occasional flush and reset.
    repeat (400) cycle($urandom_range(0, 1), $urandom_range(0, 1),
                       $urandom_range(0, 19) == 0, $urandom_range(0, 1),
                       $urandom_range(0, 49) == 0);

    begin
      int waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clk);
        waited++;
      end
      if (exp_q.size() > 0) begin
        failures++;
        $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
